// File: rtl/noc_params.sv
// rtl/noc_params.sv - shared NoC parameters and flit type
// Purpose: VC count, destination address widths and the flit_t layout
//          that the network interface and the router input ports share.
package noc_params;

   localparam int VC_NUM            = 2;
   localparam int VC_SIZE           = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
   localparam int DEST_ADDR_SIZE_X  = 2;
   localparam int DEST_ADDR_SIZE_Y  = 2;
   localparam int FLIT_DATA_SIZE    = 16;
   localparam int HEAD_PAYLOAD_SIZE = FLIT_DATA_SIZE - DEST_ADDR_SIZE_X - DEST_ADDR_SIZE_Y;

   typedef enum logic [1:0] {HEAD, BODY, TAIL, HEADTAIL} flit_label_t;

   typedef struct packed {
      logic [DEST_ADDR_SIZE_X-1:0]  x_dest;
      logic [DEST_ADDR_SIZE_Y-1:0]  y_dest;
      logic [HEAD_PAYLOAD_SIZE-1:0] head_pl;
   } head_data_t;

   typedef union packed {
      head_data_t                head_data;
      logic [FLIT_DATA_SIZE-1:0] bt_pl;
   } flit_data_t;

   typedef struct packed {
      flit_label_t        flit_label;
      logic [VC_SIZE-1:0] vc_id;
      flit_data_t         data;
   } flit_t;

endpackage

// File: rtl/ni_flit_injector_if.sv
// rtl/ni_flit_injector_if.sv - handshake bundle of the flit injector
// Purpose: groups the packet request, payload stream, per-VC on_off and
//          flit output of ni_flit_injector.
// Ports (slave = injector side):
//   pkt_valid_i/pkt_ready_o, x_dest_i, y_dest_i, pkt_len_i : packet request
//   payload_valid_i/payload_ready_o, payload_i             : body/tail beats
//   on_off_i                                               : downstream VC credit state
//   data_o, valid_flit_o, busy_o                           : flit output / status
interface ni_flit_injector_if #(
   parameter int MAX_PKT_LEN = 16
);
   import noc_params::*;

   localparam int LEN_W = $clog2(MAX_PKT_LEN + 1);

   logic                        pkt_valid_i;
   logic                        pkt_ready_o;
   logic [DEST_ADDR_SIZE_X-1:0] x_dest_i;
   logic [DEST_ADDR_SIZE_Y-1:0] y_dest_i;
   logic [LEN_W-1:0]            pkt_len_i;
   logic                        payload_valid_i;
   logic [FLIT_DATA_SIZE-1:0]   payload_i;
   logic                        payload_ready_o;
   logic [VC_NUM-1:0]           on_off_i;
   flit_t                       data_o;
   logic                        valid_flit_o;
   logic                        busy_o;

   modport master (
      output pkt_valid_i, x_dest_i, y_dest_i, pkt_len_i,
      output payload_valid_i, payload_i, on_off_i,
      input  pkt_ready_o, payload_ready_o, data_o, valid_flit_o, busy_o
   );

   modport slave (
      input  pkt_valid_i, x_dest_i, y_dest_i, pkt_len_i,
      input  payload_valid_i, payload_i, on_off_i,
      output pkt_ready_o, payload_ready_o, data_o, valid_flit_o, busy_o
   );

endinterface

// File: rtl/ni_flit_injector.sv
// rtl/ni_flit_injector.sv - NI transmitter turning packet requests into wormhole flits
// Purpose: accepts (dest, len) requests plus a payload stream and emits
//          HEAD/BODY/TAIL or HEADTAIL flits on one VC per packet, the VC
//          picked round-robin among those whose on_off bit is set.
// Ports:
//   clk   : clock, all state on the rising edge
//   rst_n : asynchronous active-low reset
//   nif   : ni_flit_injector_if.slave (request, payload, on_off, flit out, busy)
module ni_flit_injector
   import noc_params::*;
#(
   parameter int MAX_PKT_LEN = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   ni_flit_injector_if.slave   nif
);

   localparam int LEN_W = $clog2(MAX_PKT_LEN + 1);

   typedef enum logic [1:0] {S_IDLE, S_ALLOC, S_PAYLOAD} state_t;

   state_t                      state_q, state_d;
   logic [DEST_ADDR_SIZE_X-1:0] x_q, x_d;
   logic [DEST_ADDR_SIZE_Y-1:0] y_q, y_d;
   logic [LEN_W-1:0]            len_q, len_d;
   logic [LEN_W-1:0]            remaining_q, remaining_d;
   logic [VC_SIZE-1:0]          rr_ptr_q, rr_ptr_d;
   logic [VC_SIZE-1:0]          cur_vc_q, cur_vc_d;
   flit_t                       data_q, data_d;
   logic                        valid_q, valid_d;

   logic                        pkt_ready;
   logic                        payload_ready;
   logic                        beat_fire;
   logic                        vc_found;
   logic [VC_SIZE-1:0]          vc_sel;
   logic [LEN_W-1:0]            len_sat;

   // 0 means a lone head; oversize requests are clipped to the packet limit.
   always_comb begin
      len_sat = nif.pkt_len_i;
      if (nif.pkt_len_i == '0) begin
         len_sat = LEN_W'(1);
      end else if (nif.pkt_len_i > LEN_W'(MAX_PKT_LEN)) begin
         len_sat = LEN_W'(MAX_PKT_LEN);
      end
   end

   // Round-robin search over on_off, starting at rr_ptr and wrapping.
   always_comb begin
      logic [VC_SIZE-1:0] idx;
      vc_found = 1'b0;
      vc_sel   = '0;
      idx      = '0;
      for (int i = 0; i < VC_NUM; i++) begin
         idx = VC_SIZE'((int'(rr_ptr_q) + i) % VC_NUM);
         if (!vc_found && nif.on_off_i[idx]) begin
            vc_found = 1'b1;
            vc_sel   = idx;
         end
      end
   end

   // Only the packet's own VC gates the stream; other on_off bits are ignored.
   assign beat_fire = (state_q == S_PAYLOAD) && nif.payload_valid_i && nif.on_off_i[cur_vc_q];

   // State register and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         x_q         <= '0;
         y_q         <= '0;
         len_q       <= '0;
         remaining_q <= '0;
         rr_ptr_q    <= '0;
         cur_vc_q    <= '0;
         data_q      <= '0;
         valid_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         y_q         <= y_d;
         len_q       <= len_d;
         remaining_q <= remaining_d;
         rr_ptr_q    <= rr_ptr_d;
         cur_vc_q    <= cur_vc_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (nif.pkt_valid_i) state_d = S_ALLOC;
         end
         S_ALLOC: begin
            if (vc_found) state_d = (len_q == LEN_W'(1)) ? S_IDLE : S_PAYLOAD;
         end
         S_PAYLOAD: begin
            if (beat_fire && remaining_q == LEN_W'(1)) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output and datapath next-value logic.
   always_comb begin
      pkt_ready     = (state_q == S_IDLE);
      payload_ready = (state_q == S_PAYLOAD) && nif.on_off_i[cur_vc_q];
      x_d           = x_q;
      y_d           = y_q;
      len_d         = len_q;
      remaining_d   = remaining_q;
      rr_ptr_d      = rr_ptr_q;
      cur_vc_d      = cur_vc_q;
      data_d        = data_q;
      valid_d       = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (nif.pkt_valid_i) begin
               x_d   = nif.x_dest_i;
               y_d   = nif.y_dest_i;
               len_d = len_sat;
            end
         end
         S_ALLOC: begin
            if (vc_found) begin
               cur_vc_d = vc_sel;
               rr_ptr_d = (vc_sel == VC_SIZE'(VC_NUM - 1)) ? '0 : vc_sel + VC_SIZE'(1);
               data_d                        = '0;
               data_d.flit_label             = (len_q == LEN_W'(1)) ? HEADTAIL : HEAD;
               data_d.vc_id                  = vc_sel;
               data_d.data.head_data.x_dest  = x_q;
               data_d.data.head_data.y_dest  = y_q;
               valid_d                       = 1'b1;
               remaining_d                   = len_q - LEN_W'(1);
            end
         end
         S_PAYLOAD: begin
            if (beat_fire) begin
               data_d.flit_label = (remaining_q == LEN_W'(1)) ? TAIL : BODY;
               data_d.vc_id      = cur_vc_q;
               data_d.data.bt_pl = nif.payload_i;
               valid_d           = 1'b1;
               remaining_d       = remaining_q - LEN_W'(1);
            end
         end
         default: ;
      endcase
   end

   assign nif.pkt_ready_o     = pkt_ready;
   assign nif.payload_ready_o = payload_ready;
   assign nif.data_o          = data_q;
   assign nif.valid_flit_o    = valid_q;
   assign nif.busy_o          = (state_q != S_IDLE);

endmodule

// File: tb/tb_ni_flit_injector.sv
// tb/tb_ni_flit_injector.sv - directed self-checking bench for ni_flit_injector
module tb_ni_flit_injector;
   import noc_params::*;

   typedef struct {
      flit_t f;
      int    c;
   } rec_t;

   logic clk;
   logic rst_n;
   int   cyc;
   int   n_total;
   int   n_bad;
   rec_t q[$];

   ni_flit_injector_if #(.MAX_PKT_LEN(16)) nif ();

   ni_flit_injector #(.MAX_PKT_LEN(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .nif   (nif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Flit monitor: record each flit with the edge count it was registered on.
   always @(negedge clk) begin
      if (rst_n && nif.valid_flit_o) begin
         rec_t r;
         r.f = nif.data_o;
         r.c = cyc;
         q.push_back(r);
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_req(input logic [1:0] x, input logic [1:0] y, input logic [4:0] len,
                           output int acc_edge);
      int n;
      n = 0;
      nif.x_dest_i    = x;
      nif.y_dest_i    = y;
      nif.pkt_len_i   = len;
      nif.pkt_valid_i = 1'b1;
      while (!nif.pkt_ready_o && n < 100) begin
         tick();
         n++;
      end
      if (n >= 100) chk("req_timeout", 0, 1);
      tick();
      acc_edge        = cyc;
      nif.pkt_valid_i = 1'b0;
   endtask

   task automatic send_beats(input int n, input logic [15:0] base);
      for (int k = 0; k < n; k++) begin
         logic acc;
         int   guard;
         nif.payload_valid_i = 1'b1;
         nif.payload_i       = base + 16'(k);
         guard = 0;
         acc   = 1'b0;
         while (!acc && guard < 200) begin
            @(negedge clk);
            #2;
            acc = nif.payload_ready_o;
            tick();
            guard++;
         end
         if (!acc) chk("beat_timeout", 0, 1);
      end
      nif.payload_valid_i = 1'b0;
   endtask

   task automatic get_flit(output flit_t f, output int c);
      int n;
      n = 0;
      while (q.size() == 0 && n < 100) begin
         tick();
         n++;
      end
      if (q.size() == 0) begin
         chk("flit_timeout", 0, 1);
         f = '0;
         c = -1;
      end else begin
         rec_t r;
         r = q.pop_front();
         f = r.f;
         c = r.c;
      end
   endtask

   initial begin
      flit_t f;
      int    c;
      int    a;
      int    h;
      int    n;

      n_total = 0;
      n_bad   = 0;
      rst_n               = 1'b0;
      nif.pkt_valid_i     = 1'b0;
      nif.x_dest_i        = '0;
      nif.y_dest_i        = '0;
      nif.pkt_len_i       = '0;
      nif.payload_valid_i = 1'b0;
      nif.payload_i       = '0;
      nif.on_off_i        = 2'b11;

      // Reset state
      repeat (3) tick();
      chk("rst_valid", nif.valid_flit_o, 0);
      chk("rst_busy", nif.busy_o, 0);
      chk("rst_pkt_ready", nif.pkt_ready_o, 1);
      chk("rst_pl_ready", nif.payload_ready_o, 0);
      chk("rst_data", nif.data_o, 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Single-flit packets alternate VCs
      send_req(2'd1, 2'd2, 5'd1, a);
      get_flit(f, c);
      chk("t2_lbl", f.flit_label, HEADTAIL);
      chk("t2_vc", f.vc_id, 0);
      chk("t2_x", f.data.head_data.x_dest, 1);
      chk("t2_y", f.data.head_data.y_dest, 2);
      chk("t2_lat", c, a + 1);
      send_req(2'd1, 2'd2, 5'd1, a);
      get_flit(f, c);
      chk("t2b_lbl", f.flit_label, HEADTAIL);
      chk("t2b_vc", f.vc_id, 1);

      // Back-to-back 4-flit packet
      send_req(2'd2, 2'd3, 5'd4, a);
      send_beats(3, 16'h00A0);
      for (int k = 0; k < 4; k++) begin
         get_flit(f, c);
         chk("t3_cyc", c, a + 1 + k);
         chk("t3_vc", f.vc_id, 0);
         case (k)
            0: chk("t3_lbl0", f.flit_label, HEAD);
            1: chk("t3_lbl1", f.flit_label, BODY);
            2: chk("t3_lbl2", f.flit_label, BODY);
            default: chk("t3_lbl3", f.flit_label, TAIL);
         endcase
         if (k > 0) chk("t3_pl", f.data.bt_pl, 16'h00A0 + 16'(k - 1));
      end

      // Stall on own VC for 3 cycles after first BODY
      fork
         begin
            send_req(2'd0, 2'd1, 5'd4, a);
            send_beats(3, 16'h00B0);
         end
         begin
            n = 0;
            do begin
               @(negedge clk);
               n++;
            end while (!(nif.valid_flit_o && nif.data_o.flit_label == BODY) && n < 60);
            if (n >= 60) chk("t4_body_timeout", 0, 1);
            nif.on_off_i = 2'b01;
            #1;
            chk("t4_rdy_low0", nif.payload_ready_o, 0);
            @(negedge clk);
            #1;
            chk("t4_rdy_low1", nif.payload_ready_o, 0);
            @(negedge clk);
            #1;
            chk("t4_rdy_low2", nif.payload_ready_o, 0);
            @(negedge clk);
            nif.on_off_i = 2'b11;
         end
      join
      get_flit(f, c);
      h = c;
      chk("t4_head", f.flit_label, HEAD);
      chk("t4_vc0", f.vc_id, 1);
      get_flit(f, c);
      chk("t4_a_cyc", c, h + 1);
      chk("t4_vc1", f.vc_id, 1);
      get_flit(f, c);
      chk("t4_b_cyc", c, h + 5);
      chk("t4_b_pl", f.data.bt_pl, 16'h00B1);
      chk("t4_vc2", f.vc_id, 1);
      get_flit(f, c);
      chk("t4_tail", f.flit_label, TAIL);
      chk("t4_t_cyc", c, h + 6);
      chk("t4_vc3", f.vc_id, 1);

      // No VC available in ALLOC, then only VC1
      nif.on_off_i = 2'b00;
      send_req(2'd3, 2'd0, 5'd1, a);
      repeat (5) tick();
      chk("t5_busy", nif.busy_o, 1);
      chk("t5_noflit", q.size(), 0);
      chk("t5_pkt_ready", nif.pkt_ready_o, 0);
      nif.on_off_i = 2'b10;
      get_flit(f, c);
      chk("t5_cyc", c, a + 6);
      chk("t5_vc", f.vc_id, 1);
      chk("t5_lbl", f.flit_label, HEADTAIL);
      chk("t5_x", f.data.head_data.x_dest, 3);
      nif.on_off_i = 2'b11;
      send_req(2'd0, 2'd0, 5'd1, a);
      get_flit(f, c);
      chk("t5_wrap_vc", f.vc_id, 0);

      // Length boundaries
      send_req(2'd1, 2'd1, 5'd0, a);
      get_flit(f, c);
      chk("t6_len0_lbl", f.flit_label, HEADTAIL);
      chk("t6_len0_vc", f.vc_id, 1);
      send_req(2'd2, 2'd1, 5'd20, a);
      send_beats(15, 16'h0100);
      for (int k = 0; k < 16; k++) begin
         get_flit(f, c);
         chk("t6_vc", f.vc_id, 0);
         if (k == 0) chk("t6_lbl_head", f.flit_label, HEAD);
         else if (k == 15) chk("t6_lbl_tail", f.flit_label, TAIL);
         else chk("t6_lbl_body", f.flit_label, BODY);
         if (k > 0) chk("t6_pl", f.data.bt_pl, 16'h0100 + 16'(k - 1));
      end
      repeat (5) tick();
      chk("t6_extra", q.size(), 0);
      chk("t6_busy", nif.busy_o, 0);

      // Reset mid-packet
      send_req(2'd0, 2'd1, 5'd4, a);
      nif.payload_valid_i = 1'b1;
      nif.payload_i       = 16'h0055;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!nif.valid_flit_o && n < 20);
      chk("t1_head_seen", nif.valid_flit_o, 1);
      rst_n = 1'b0;
      #1;
      chk("t1_valid_now", nif.valid_flit_o, 0);
      chk("t1_busy_now", nif.busy_o, 0);
      chk("t1_pl_ready", nif.payload_ready_o, 0);
      q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) tick();
      chk("t1_noflit", q.size(), 0);
      chk("t1_busy", nif.busy_o, 0);
      chk("t1_pkt_ready", nif.pkt_ready_o, 1);
      nif.payload_valid_i = 1'b0;

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
